// File: rtl/csa_sub_seq.sv
// csa_sub_seq: slice-serial carry-select subtractor.
// Computes (term1 - term2) mod 2^WIDTH as a + ~b + 1, one 4-bit slice per cycle.
// Each slice forms both carry-in candidates and picks one with the registered carry.
// A partial top slice covers WIDTH values that are not a multiple of 4.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     operand handshake (i_sub_term1 minuend, i_sub_term2 subtrahend)
//   o_valid / i_ready     result handshake
//   o_diff                (term1 - term2) mod 2^WIDTH, meaningful while o_valid=1
//   o_borrow              1 when term1 < term2 (unsigned)
module csa_sub_seq #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned NSLICE     = (WIDTH + SLICE - 1) / SLICE;
  localparam int unsigned BIT_REMAIN = WIDTH % SLICE;
  // Operands and result are held zero-padded to a whole number of slices.
  localparam int unsigned PW         = NSLICE * SLICE;
  localparam int unsigned KW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [KW-1:0] LAST_K   = KW'(NSLICE - 1);
  localparam logic [3:0]    TOP_MASK = (BIT_REMAIN == 0) ? 4'hF : 4'((1 << BIT_REMAIN) - 1);
  localparam logic [2:0]    TOP_W    = (BIT_REMAIN == 0) ? 3'd4 : 3'(BIT_REMAIN);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state_q, r_state_d;
  logic [KW-1:0]   r_k_q, r_k_d;
  logic            r_c_q, r_c_d;
  logic [PW-1:0]   r_a_q, r_a_d;
  logic [PW-1:0]   r_b_q, r_b_d;
  logic [PW-1:0]   r_diff_q, r_diff_d;
  logic            r_borrow_q, r_borrow_d;

  logic [KW+1:0]   w_base;
  logic            w_last;
  logic [3:0]      w_mask;
  logic [2:0]      w_width;
  logic [3:0]      w_a_s;
  logic [3:0]      w_nb_s;
  logic [4:0]      w_sum0;
  logic [4:0]      w_sum1;
  logic [4:0]      w_sel;
  logic            w_cout;

  // Slice datapath: one 4-bit adder pair plus the carry-select mux.
  always_comb begin
    w_base  = {r_k_q, 2'b00};
    w_last  = (r_k_q == LAST_K);
    w_mask  = w_last ? TOP_MASK : 4'hF;
    w_width = w_last ? TOP_W : 3'd4;
    // Bits above the slice width are forced to zero so the carry lands exactly at
    // bit w_width of the 5-bit sum, also for the partial top slice.
    w_a_s   = r_a_q[w_base +: 4] & w_mask;
    w_nb_s  = ~r_b_q[w_base +: 4] & w_mask;
    w_sum0  = {1'b0, w_a_s} + {1'b0, w_nb_s};
    w_sum1  = {1'b0, w_a_s} + {1'b0, w_nb_s} + 5'd1;
    w_sel   = r_c_q ? w_sum1 : w_sum0;
    w_cout  = w_sel[w_width];
  end

  always_comb begin
    r_state_d  = r_state_q;
    r_k_d      = r_k_q;
    r_c_d      = r_c_q;
    r_a_d      = r_a_q;
    r_b_d      = r_b_q;
    r_diff_d   = r_diff_q;
    r_borrow_d = r_borrow_q;

    unique case (r_state_q)
      StIdle: begin
        if (i_valid) begin
          r_a_d     = PW'(i_sub_term1);
          r_b_d     = PW'(i_sub_term2);
          r_k_d     = '0;
          r_c_d     = 1'b1;  // the +1 of a + ~b + 1
          r_state_d = StRun;
        end
      end
      StRun: begin
        r_diff_d[w_base +: 4] = w_sel[3:0] & w_mask;
        r_c_d                 = w_cout;
        if (w_last) begin
          r_borrow_d = ~w_cout;
          r_k_d      = '0;
          r_state_d  = StDone;
        end else begin
          r_k_d = r_k_q + KW'(1);
        end
      end
      StDone: begin
        if (i_ready) begin
          r_state_d = StIdle;
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q  <= StIdle;
      r_k_q      <= '0;
      r_c_q      <= 1'b0;
      r_a_q      <= '0;
      r_b_q      <= '0;
      r_diff_q   <= '0;
      r_borrow_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_k_q      <= r_k_d;
      r_c_q      <= r_c_d;
      r_a_q      <= r_a_d;
      r_b_q      <= r_b_d;
      r_diff_q   <= r_diff_d;
      r_borrow_q <= r_borrow_d;
    end
  end

  assign o_ready  = (r_state_q == StIdle);
  assign o_valid  = (r_state_q == StDone);
  assign o_diff   = r_diff_q[WIDTH-1:0];
  assign o_borrow = r_borrow_q;

  // Padding bits of the result register never reach the output.
  if (PW > WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^r_diff_q[PW-1:WIDTH];
  end

endmodule

// File: tb/tb_csa_sub_seq.sv
module tb_csa_sub_seq;

  logic clk;
  logic rst;

  logic       v5, rdy5_o, vo5, rdy5_i, bw5;
  logic [4:0] a5, b5, d5;
  logic       v8, rdy8_o, vo8, rdy8_i, bw8;
  logic [7:0] a8, b8, d8;

  int n_vec;
  int n_err;

  csa_sub_seq #(.WIDTH(5), .SLICE(4)) u_dut5 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (v5),
    .o_ready    (rdy5_o),
    .i_sub_term1(a5),
    .i_sub_term2(b5),
    .o_valid    (vo5),
    .i_ready    (rdy5_i),
    .o_diff     (d5),
    .o_borrow   (bw5)
  );

  csa_sub_seq #(.WIDTH(8), .SLICE(4)) u_dut8 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (v8),
    .o_ready    (rdy8_o),
    .i_sub_term1(a8),
    .i_sub_term2(b8),
    .o_valid    (vo8),
    .i_ready    (rdy8_i),
    .o_diff     (d8),
    .o_borrow   (bw8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=5 transaction. hold: cycles of i_ready=0 after o_valid.
  // scramble: drive junk operands with i_valid=1 while the block is busy.
  task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic [4:0] ed,
                      input logic eb, input int hold, input bit scramble, input string tag);
    check({tag, ".idle_ready"}, 32'(rdy5_o), 32'd1);
    rdy5_i = (hold == 0);
    v5 = 1'b1;
    a5 = a;
    b5 = b;
    tick();  // acceptance edge E
    check({tag, ".busy"}, 32'(rdy5_o), 32'd0);
    if (scramble) begin
      a5 = ~a;
      b5 = b ^ 5'h15;
    end else begin
      v5 = 1'b0;
    end
    tick();  // E+1
    check({tag, ".valid_e1"}, 32'(vo5), 32'd0);
    tick();  // E+2
    check({tag, ".valid_e2"}, 32'(vo5), 32'd1);
    check({tag, ".diff"}, 32'(d5), 32'(ed));
    check({tag, ".borrow"}, 32'(bw5), 32'(eb));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_diff"}, 32'(d5), 32'(ed));
      check({tag, ".hold_borrow"}, 32'(bw5), 32'(eb));
      check({tag, ".hold_valid"}, 32'(vo5), 32'd1);
      check({tag, ".hold_ready"}, 32'(rdy5_o), 32'd0);
    end
    v5 = 1'b0;
    rdy5_i = 1'b1;
    tick();  // handshake edge F
    check({tag, ".ready_after"}, 32'(rdy5_o), 32'd1);
    check({tag, ".valid_after"}, 32'(vo5), 32'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic eb, input string tag);
    check({tag, ".idle_ready"}, 32'(rdy8_o), 32'd1);
    v8 = 1'b1;
    a8 = a;
    b8 = b;
    tick();
    v8 = 1'b0;
    check({tag, ".busy"}, 32'(rdy8_o), 32'd0);
    tick();
    check({tag, ".valid_e1"}, 32'(vo8), 32'd0);
    tick();
    check({tag, ".valid_e2"}, 32'(vo8), 32'd1);
    check({tag, ".diff"}, 32'(d8), 32'(ed));
    check({tag, ".borrow"}, 32'(bw8), 32'(eb));
    tick();
    check({tag, ".ready_after"}, 32'(rdy8_o), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    v5 = 1'b0; a5 = '0; b5 = '0; rdy5_i = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; rdy8_i = 1'b1;
    tick();
    tick();
    check("rst.ready5", 32'(rdy5_o), 32'd1);
    check("rst.valid5", 32'(vo5), 32'd0);
    check("rst.diff5", 32'(d5), 32'd0);
    check("rst.borrow5", 32'(bw5), 32'd0);
    check("rst.ready8", 32'(rdy8_o), 32'd1);
    check("rst.valid8", 32'(vo8), 32'd0);
    rst = 1'b0;
    tick();

    run5(5'd7,  5'd3,  5'd4,  1'b0, 0, 1'b0, "w5_7m3");
    run5(5'd3,  5'd7,  5'd28, 1'b1, 0, 1'b0, "w5_3m7");
    run5(5'd16, 5'd1,  5'd15, 1'b0, 0, 1'b0, "w5_16m1");
    run5(5'd31, 5'd31, 5'd0,  1'b0, 0, 1'b0, "w5_31m31");
    run5(5'd0,  5'd0,  5'd0,  1'b0, 0, 1'b0, "w5_0m0");
    run5(5'd5,  5'd9,  5'd28, 1'b1, 5, 1'b0, "w5_bp");
    run5(5'd20, 5'd6,  5'd14, 1'b0, 0, 1'b1, "w5_scr");

    run8(8'h00, 8'h01, 8'hFF, 1'b1, "w8_0m1");
    run8(8'hA5, 8'h5A, 8'h4B, 1'b0, "w8_a5m5a");
    run8(8'h80, 8'h7F, 8'h01, 1'b0, "w8_80m7f");

    // Reset one cycle after acceptance: the operation is discarded.
    v5 = 1'b1;
    a5 = 5'd30;
    b5 = 5'd1;
    tick();  // accepted
    v5 = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst.ready", 32'(rdy5_o), 32'd1);
    check("mrst.valid", 32'(vo5), 32'd0);
    check("mrst.diff", 32'(d5), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst.no_stale", 32'(vo5), 32'd0);
    end
    run5(5'd9, 5'd2, 5'd7, 1'b0, 0, 1'b0, "w5_9m2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
